// File: rtl/csram_stream.sv
// Neuron-parameter memory: narrow config stream packed into wide entries, 1-cycle
// read-first read port, and an in-place field-write port merged into commits.
module csram_stream #(
    parameter int unsigned NUM_NEURONS = 256,
    parameter int unsigned WIDTH       = 368,
    parameter int unsigned NARROW      = 16,
    parameter int unsigned FIELD_LSB   = 102,
    parameter int unsigned FIELD_WIDTH = 9,
    localparam int unsigned ADDR_W     = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [NARROW-1:0]      cfg_data,
    output logic                   cfg_done,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   fw_en,
    input  logic [ADDR_W-1:0]      fw_addr,
    input  logic [FIELD_WIDTH-1:0] fw_data
);

    localparam int unsigned WORDS  = (WIDTH + NARROW - 1) / NARROW;
    localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LAST_W = WIDTH - (WORDS - 1) * NARROW;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        LOAD,
        COMMIT,
        DONE
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [WIDTH-1:0]    buf_q;
    logic                cfg_ready_q;
    logic                cfg_done_q;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic [WIDTH-1:0]    mem_q [NUM_NEURONS];

    logic                beat_acc;
    logic                commit_en;
    logic                fw_hit;
    logic [WIDTH-1:0]    commit_data;

    assign beat_acc  = cfg_valid && cfg_ready_q;
    assign commit_en = (state_q == COMMIT);
    assign fw_hit    = fw_en && (fw_addr == ptr_q);

    // Loader FSM; cfg_ready/cfg_done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            ptr_q       <= '0;
            beat_q      <= '0;
            buf_q       <= '0;
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else if (cfg_start) begin
            state_q     <= LOAD;
            ptr_q       <= '0;
            beat_q      <= '0;
            cfg_ready_q <= 1'b1;
            cfg_done_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    cfg_ready_q <= 1'b1;
                    if (beat_acc) begin
                        for (int unsigned w = 0; w + 1 < WORDS; w++) begin
                            if (beat_q == BEAT_W'(w)) begin
                                buf_q[w*NARROW +: NARROW] <= cfg_data;
                            end
                        end
                        // Final beat keeps only the bits that fit in the entry.
                        if (beat_q == LAST_BEAT) begin
                            buf_q[(WORDS-1)*NARROW +: LAST_W] <= cfg_data[LAST_W-1:0];
                            beat_q      <= '0;
                            state_q     <= COMMIT;
                            cfg_ready_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q     <= DONE;
                        cfg_done_q  <= 1'b1;
                        cfg_ready_q <= 1'b0;
                    end else begin
                        ptr_q       <= ptr_q + 1'b1;
                        state_q     <= LOAD;
                        cfg_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    cfg_ready_q <= 1'b0;
                end
                default: begin
                    state_q     <= LOAD;
                    cfg_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        commit_data = buf_q;
        if (fw_hit) begin
            commit_data[FIELD_LSB +: FIELD_WIDTH] = fw_data;
        end
    end

    // Same-address field write is folded into the commit word instead of racing it.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem_q[ptr_q] <= commit_data;
        end
        if (fw_en && !(commit_en && fw_hit)) begin
            mem_q[fw_addr][FIELD_LSB +: FIELD_WIDTH] <= fw_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_done  = cfg_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_csram_stream.sv
// Randomised scoreboard bench for csram_stream against a transaction-level memory model.
module tb_csram_stream;

    localparam int N     = 4;
    localparam int W     = 40;
    localparam int NW    = 16;
    localparam int FL    = 8;
    localparam int FW    = 9;
    localparam int AW    = 2;
    localparam int WORDS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [NW-1:0] cfg_data = '0;
    logic          cfg_done;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          fw_en = 1'b0;
    logic [AW-1:0] fw_addr = '0;
    logic [FW-1:0] fw_data = '0;

    always #5 clk = ~clk;

    csram_stream #(
        .NUM_NEURONS(N),
        .WIDTH(W),
        .NARROW(NW),
        .FIELD_LSB(FL),
        .FIELD_WIDTH(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data(cfg_data),
        .cfg_done(cfg_done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .fw_en(fw_en),
        .fw_addr(fw_addr),
        .fw_data(fw_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;
    bit exp_rv   = 1'b0;
    logic [W-1:0] sb [$];

    // Reference model: memory contents plus load progress in terms of beats and entries.
    logic [W-1:0]  m_mem [N];
    logic [NW-1:0] m_beats [$];
    logic [W-1:0]  m_word = '0;
    int            m_ptr = 0;
    bit            m_commit = 1'b0;
    bit            m_done = 1'b0;
    bit            m_ready = 1'b0;
    bit            m_acc = 1'b0;
    int            cyc = 0;

    logic [NW-1:0] src [$];
    int            coll_addr = -1;
    logic [FW-1:0] coll_data = '0;
    bit            rnd_rd = 1'b0;
    int            first_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no read", rd_data);
                end else begin
                    chk("rd_data", 64'(rd_data), 64'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        logic [W-1:0]      nxt [N];
        logic [NW*WORDS-1:0] cat;
        chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
        chk("cfg_done", 64'(cfg_done), 64'(m_done));
        m_acc = cfg_valid && m_ready;
        nxt = m_mem;
        if (!rst && rd_en) sb.push_back(m_mem[rd_addr]);
        if (m_commit) nxt[m_ptr] = m_word;
        if (fw_en) nxt[fw_addr][FL +: FW] = fw_data;
        if (rst) begin
            m_ready = 0; m_done = 0; m_ptr = 0; m_commit = 0; m_acc = 0;
            m_beats.delete();
        end else if (cfg_start) begin
            m_ready = 1; m_done = 0; m_ptr = 0; m_commit = 0; m_acc = 0;
            m_beats.delete();
        end else if (m_commit) begin
            m_commit = 0;
            if (m_ptr == N - 1) begin
                m_done = 1; m_ready = 0;
            end else begin
                m_ptr++; m_ready = 1;
            end
        end else if (!m_done) begin
            if (m_acc) begin
                m_beats.push_back(cfg_data);
                if (m_beats.size() == WORDS) begin
                    cat = '0;
                    for (int i = 0; i < WORDS; i++) cat = cat | ((NW*WORDS)'(m_beats[i]) << (i * NW));
                    m_word = cat[W-1:0];
                    m_beats.delete();
                    m_commit = 1;
                end
            end
            m_ready = !m_commit;
        end
        @(posedge clk);
        m_mem  = nxt;
        exp_rv = rd_en && !rst;
        cyc++;
        @(negedge clk);
        rst = 0; cfg_start = 0; cfg_valid = 0; rd_en = 0; fw_en = 0;
    endtask

    task automatic feed(input int n, input int maxgap);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 400) begin
            repeat ($urandom_range(0, maxgap)) tick();
            cfg_valid = 1;
            cfg_data  = src[sent];
            if (rnd_rd && $urandom_range(0, 1) == 1) begin
                rd_en = 1; rd_addr = AW'($urandom_range(0, N - 1));
            end
            if (m_commit && m_ptr == coll_addr) begin
                fw_en = 1; fw_addr = AW'(coll_addr); fw_data = coll_data;
            end
            tick();
            if (m_acc) begin
                if (sent == 0) first_cyc = cyc - 1;
                sent++;
            end
            guard++;
        end
        if (sent < n) begin
            n_checks++; n_fail++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", sent, n);
        end
    endtask

    task automatic wait_done();
        int i = 0;
        while (!cfg_done && i < 60) begin
            tick();
            i++;
        end
        if (!cfg_done) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got cfg_done=0 expected 1");
        end
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = AW'(a);
        tick();
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a++) rd(a);
        tick();
    endtask

    task automatic new_src();
        src.delete();
        for (int i = 0; i < N * WORDS; i++) src.push_back(NW'($urandom));
    endtask

    initial begin
        logic [W-1:0] old;
        logic [W-1:0] e;
        logic [NW*WORDS-1:0] c;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        started = 1;
        chk("reset_ready", 64'(cfg_ready), 64'd0);
        chk("reset_done", 64'(cfg_done), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1;
        tick();
        tick();

        // Full back-to-back load with known beats.
        for (int i = 0; i < N * WORDS; i++) src.push_back(NW'(i + 1));
        rnd_rd = 1;
        feed(N * WORDS, 0);
        wait_done();
        chk("done_latency", 64'(cyc - first_cyc), 64'd16);
        rd(0);
        chk("entry0_pack", 64'(rd_data), 64'h03_0002_0001);
        read_all();

        // Same data with gaps and with no gaps.
        new_src();
        cfg_start = 1; tick();
        feed(N * WORDS, 3);
        wait_done();
        read_all();
        cfg_start = 1; tick();
        feed(N * WORDS, 0);
        wait_done();
        read_all();

        // Field write, with a same-cycle read seeing the old value.
        old = m_mem[2];
        fw_en = 1; fw_addr = 2; fw_data = 9'h1FF;
        rd_en = 1; rd_addr = 2;
        tick();
        chk("fw_readfirst", 64'(rd_data), 64'(old));
        rd(2);
        e = old; e[16:8] = 9'h1FF;
        chk("fw_merge", 64'(rd_data), 64'(e));

        // Collision between commit of entry 1 and a field write to entry 1.
        new_src();
        cfg_start = 1; tick();
        coll_addr = 1; coll_data = 9'h0AA;
        feed(N * WORDS, 1);
        coll_addr = -1;
        wait_done();
        rd(1);
        c = {src[5], src[4], src[3]};
        e = c[W-1:0]; e[16:8] = 9'h0AA;
        chk("collision", 64'(rd_data), 64'(e));
        read_all();

        // Restart mid-load; the beat offered with cfg_start is discarded.
        new_src();
        cfg_start = 1; tick();
        feed(5, 0);
        cfg_start = 1; cfg_valid = 1; cfg_data = 16'hDEAD;
        tick();
        new_src();
        feed(N * WORDS, 0);
        wait_done();
        read_all();

        // Reset mid-load.
        new_src();
        cfg_start = 1; tick();
        feed(7, 0);
        rst = 1; tick();
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        tick();
        read_all();

        // Random traffic on every port.
        for (int i = 0; i < 400; i++) begin
            cfg_valid = $urandom_range(0, 3) != 0;
            cfg_data  = NW'($urandom);
            cfg_start = $urandom_range(0, 59) == 0;
            rst       = $urandom_range(0, 119) == 0;
            rd_en     = $urandom_range(0, 1) == 1;
            rd_addr   = AW'($urandom_range(0, N - 1));
            fw_en     = $urandom_range(0, 3) == 0;
            fw_addr   = AW'($urandom_range(0, N - 1));
            fw_data   = FW'($urandom);
            tick();
        end
        read_all();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
